// File: rtl/oric_ram_sched.sv
`timescale 1ns/1ps
// oric_ram_sched: shares the single main-RAM port between the CPU/ULA bus and the tape loader.
// Optional macro RAM_CLEAR_EN: sweep CLR_VAL over all 64 KiB after every reset.
module oric_ram_sched #(
  parameter logic [7:0]  CLR_VAL    = 8'hFF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic        i_cpu_cs,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_a,
  input  logic [7:0]  i_cpu_d,
  output logic        o_cpu_wait,
  output logic [7:0]  o_cpu_q,
  output logic        o_cpu_qv,
  input  logic        i_tape_wr,
  input  logic [15:0] i_tape_a,
  input  logic [7:0]  i_tape_d,
  output logic        o_tape_ready,
  input  logic        i_tape_done,
  output logic        o_load_done,
  output logic        o_tape_ovf,
  output logic        o_busy,
  output logic        o_ram_ce,
  output logic        o_ram_we,
  output logic [15:0] o_ram_a,
  output logic [7:0]  o_ram_d,
  input  logic [7:0]  i_ram_q
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

  typedef enum logic {StClear, StRun} state_e;

`ifdef RAM_CLEAR_EN
  localparam state_e RST_STATE = StClear;
`else
  localparam state_e RST_STATE = StRun;
`endif

  state_e           r_state, w_state_nxt;
  logic [23:0]      r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [STV_W-1:0] r_starve, w_starve_nxt;
  logic             r_ram_ce, r_ram_we;
  logic [15:0]      r_ram_a;
  logic [7:0]       r_ram_d;
  logic             r_rd_p1, r_rd_p2;
  logic [7:0]       r_cpu_q;
  logic             r_cpu_qv;
  logic             r_done_pend, r_load_done, r_ovf;
`ifdef RAM_CLEAR_EN
  logic [15:0]      r_clr_a, w_clr_a_nxt;
`endif

  logic             w_ram_ce, w_ram_we;
  logic [15:0]      w_ram_a;
  logic [7:0]       w_ram_d;
  logic             w_push, w_pop, w_rd_issue, w_cpu_wait, w_fifo_ne;
  logic [23:0]      w_head;

  assign w_fifo_ne = (r_count != '0);
  assign w_push    = i_tape_wr && (r_count != FULL_CNT);
  assign w_head    = r_fifo[r_rd_ptr];

  // Grant decision; CPU has priority unless the loader has been starved STARVE_MAX slots.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    w_ram_ce     = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_a      = r_ram_a;
    w_ram_d      = r_ram_d;
    w_pop        = 1'b0;
    w_rd_issue   = 1'b0;
    w_cpu_wait   = 1'b0;
`ifdef RAM_CLEAR_EN
    w_clr_a_nxt  = r_clr_a;
`endif
    if (r_state == StClear) begin
`ifdef RAM_CLEAR_EN
      w_cpu_wait  = 1'b1;
      w_ram_ce    = 1'b1;
      w_ram_we    = 1'b1;
      w_ram_a     = r_clr_a;
      w_ram_d     = CLR_VAL;
      w_clr_a_nxt = r_clr_a + 16'd1;
      if (r_clr_a == 16'hFFFF) begin
        w_state_nxt = StRun;
      end
`else
      w_state_nxt = StRun;
`endif
    end else if (w_fifo_ne && (r_starve == STV_LIM)) begin
      w_pop        = 1'b1;
      w_ram_ce     = 1'b1;
      w_ram_we     = 1'b1;
      w_ram_a      = w_head[23:8];
      w_ram_d      = w_head[7:0];
      w_cpu_wait   = i_cpu_cs;
      w_starve_nxt = '0;
    end else if (i_cpu_cs) begin
      w_ram_ce     = 1'b1;
      w_ram_we     = i_cpu_we;
      w_ram_a      = i_cpu_a;
      // Reads park the unused data bus at the fill byte.
      w_ram_d      = i_cpu_we ? i_cpu_d : CLR_VAL;
      w_rd_issue   = !i_cpu_we;
      w_starve_nxt = w_fifo_ne ? (r_starve + STV_W'(1)) : '0;
    end else if (w_fifo_ne) begin
      w_pop        = 1'b1;
      w_ram_ce     = 1'b1;
      w_ram_we     = 1'b1;
      w_ram_a      = w_head[23:8];
      w_ram_d      = w_head[7:0];
      w_starve_nxt = '0;
    end
  end

  // FIFO storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk_48) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {i_tape_a, i_tape_d};
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      r_state     <= RST_STATE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      r_ram_ce    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_a     <= '0;
      r_ram_d     <= '0;
      r_rd_p1     <= 1'b0;
      r_rd_p2     <= 1'b0;
      r_cpu_q     <= '0;
      r_cpu_qv    <= 1'b0;
      r_done_pend <= 1'b0;
      r_load_done <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef RAM_CLEAR_EN
      r_clr_a     <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_ram_ce <= w_ram_ce;
      r_ram_we <= w_ram_we;
      r_ram_a  <= w_ram_a;
      r_ram_d  <= w_ram_d;
`ifdef RAM_CLEAR_EN
      r_clr_a  <= w_clr_a_nxt;
`endif
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (i_tape_wr && !w_push) begin
        r_ovf <= 1'b1;
      end
      // Read return: ram_q is valid the cycle after the port read, then registered.
      r_rd_p1  <= w_rd_issue;
      r_rd_p2  <= r_rd_p1;
      r_cpu_qv <= r_rd_p2;
      if (r_rd_p2) begin
        r_cpu_q <= i_ram_q;
      end
      if (i_tape_done) begin
        r_done_pend <= 1'b1;
      end else if (w_push) begin
        r_done_pend <= 1'b0;
      end
      // An accepted byte reopens the load; done only once the queue has emptied.
      if (w_push) begin
        r_load_done <= 1'b0;
      end else if (r_done_pend && !w_fifo_ne) begin
        r_load_done <= 1'b1;
      end
    end
  end

  assign o_cpu_wait   = w_cpu_wait;
  assign o_cpu_q      = r_cpu_q;
  assign o_cpu_qv     = r_cpu_qv;
  assign o_tape_ready = (r_count != FULL_CNT);
  assign o_load_done  = r_load_done;
  assign o_tape_ovf   = r_ovf;
  assign o_busy       = (r_state == StClear);
  assign o_ram_ce     = r_ram_ce;
  assign o_ram_we     = r_ram_we;
  assign o_ram_a      = r_ram_a;
  assign o_ram_d      = r_ram_d;

endmodule

// File: tb/tb_oric_ram_sched.sv
`timescale 1ns/1ps
// Bench for oric_ram_sched: RAM-port and read-data scoreboards fed as stimulus is driven.
// Build with RAM_CLEAR_EN defined for both files to cover the clear sweep.
module tb_oric_ram_sched;

  localparam logic [7:0] ClrVal = 8'hFF;

  logic        clk_48 = 1'b0;
  logic        reset  = 1'b1;
  logic        i_cpu_cs, i_cpu_we;
  logic [15:0] i_cpu_a;
  logic [7:0]  i_cpu_d;
  logic        o_cpu_wait;
  logic [7:0]  o_cpu_q;
  logic        o_cpu_qv;
  logic        i_tape_wr;
  logic [15:0] i_tape_a;
  logic [7:0]  i_tape_d;
  logic        o_tape_ready;
  logic        i_tape_done;
  logic        o_load_done, o_tape_ovf, o_busy;
  logic        o_ram_ce, o_ram_we;
  logic [15:0] o_ram_a;
  logic [7:0]  o_ram_d;
  logic [7:0]  i_ram_q;

  always #5 clk_48 = ~clk_48;

  oric_ram_sched #(
    .CLR_VAL   (ClrVal),
    .FIFO_DEPTH(4),
    .STARVE_MAX(8)
  ) u_dut (
    .clk_48      (clk_48),
    .reset       (reset),
    .i_cpu_cs    (i_cpu_cs),
    .i_cpu_we    (i_cpu_we),
    .i_cpu_a     (i_cpu_a),
    .i_cpu_d     (i_cpu_d),
    .o_cpu_wait  (o_cpu_wait),
    .o_cpu_q     (o_cpu_q),
    .o_cpu_qv    (o_cpu_qv),
    .i_tape_wr   (i_tape_wr),
    .i_tape_a    (i_tape_a),
    .i_tape_d    (i_tape_d),
    .o_tape_ready(o_tape_ready),
    .i_tape_done (i_tape_done),
    .o_load_done (o_load_done),
    .o_tape_ovf  (o_tape_ovf),
    .o_busy      (o_busy),
    .o_ram_ce    (o_ram_ce),
    .o_ram_we    (o_ram_we),
    .o_ram_a     (o_ram_a),
    .o_ram_d     (o_ram_d),
    .i_ram_q     (i_ram_q)
  );

  // Synchronous RAM with one-cycle read latency.
  logic [7:0] mem [65536];
  always @(posedge clk_48) begin
    if (o_ram_ce) begin
      if (o_ram_we) mem[o_ram_a] <= o_ram_d;
      else          i_ram_q <= mem[o_ram_a];
    end
  end

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
  } txn_t;

  txn_t        exp_q[$];
  logic [7:0]  rd_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic we, input logic [15:0] a, input logic [7:0] d);
    txn_t t;
    t.we = we;
    t.a  = a;
    t.d  = d;
    exp_q.push_back(t);
  endtask

  txn_t       mon_e;
  logic [7:0] mon_rd;
  always @(negedge clk_48) begin
    if (o_ram_ce) begin
      if (exp_q.size() == 0) begin
        check("ram_unexpected", {31'd0, o_ram_ce}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ram_we", {31'd0, o_ram_we}, {31'd0, mon_e.we});
        check("ram_a", {16'd0, o_ram_a}, {16'd0, mon_e.a});
        if (mon_e.we) check("ram_d", {24'd0, o_ram_d}, {24'd0, mon_e.d});
      end
    end
    if (o_cpu_qv) begin
      if (rd_q.size() == 0) begin
        check("qv_unexpected", {31'd0, o_cpu_qv}, 32'd0);
      end else begin
        mon_rd = rd_q.pop_front();
        check("cpu_q", {24'd0, o_cpu_q}, {24'd0, mon_rd});
      end
    end
  end

  task automatic step();
    @(posedge clk_48);
    #1;
  endtask

  task automatic idle_inputs();
    i_cpu_cs    = 1'b0;
    i_cpu_we    = 1'b0;
    i_cpu_a     = '0;
    i_cpu_d     = '0;
    i_tape_wr   = 1'b0;
    i_tape_a    = '0;
    i_tape_d    = '0;
    i_tape_done = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check(tag, exp_q.size() + rd_q.size(), 0);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    i_cpu_cs = 1'b1;
    i_cpu_we = 1'b1;
    i_cpu_a  = a;
    i_cpu_d  = d;
    push_exp(1'b1, a, d);
    #2;
    check("wr_wait", {31'd0, o_cpu_wait}, 32'd0);
    step();
    i_cpu_cs = 1'b0;
    check("wr_lat_ce", {31'd0, o_ram_ce}, 32'd1);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp_d);
    int n;
    i_cpu_cs = 1'b1;
    i_cpu_we = 1'b0;
    i_cpu_a  = a;
    push_exp(1'b0, a, 8'h00);
    rd_q.push_back(exp_d);
    step();
    i_cpu_cs = 1'b0;
    n = 1;
    while (!o_cpu_qv && n < 10) begin
      step();
      n++;
    end
    check("rd_latency", n, 3);
  endtask

  initial begin
    logic [15:0] t2_a [3];
    logic [7:0]  t2_d [3];
    logic [5:0]  ce_exp;
    logic [5:0]  ld_exp;
    int          n;

    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    check("rst_ram_ce", {31'd0, o_ram_ce}, 32'd0);
    check("rst_ram_we", {31'd0, o_ram_we}, 32'd0);
    check("rst_ram_a", {16'd0, o_ram_a}, 32'd0);
    check("rst_ram_d", {24'd0, o_ram_d}, 32'd0);
    check("rst_cpu_q", {24'd0, o_cpu_q}, 32'd0);
    check("rst_cpu_qv", {31'd0, o_cpu_qv}, 32'd0);
    check("rst_load_done", {31'd0, o_load_done}, 32'd0);
    check("rst_tape_ovf", {31'd0, o_tape_ovf}, 32'd0);
    check("rst_tape_ready", {31'd0, o_tape_ready}, 32'd1);
`ifdef RAM_CLEAR_EN
    check("rst_busy", {31'd0, o_busy}, 32'd1);
    check("rst_cpu_wait", {31'd0, o_cpu_wait}, 32'd1);

    // Aborted sweep with stale FIFO entries and an overflow.
    reset = 1'b0;
    for (int i = 0; i < 21; i++) push_exp(1'b1, 16'(i), ClrVal);
    for (int i = 0; i < 6; i++) begin
      i_tape_wr = 1'b1;
      i_tape_a  = 16'h0800 + 16'(i);
      i_tape_d  = 8'hE0 + 8'(i);
      step();
    end
    i_tape_wr = 1'b0;
    check("clr_fifo_full", {31'd0, o_tape_ready}, 32'd0);
    check("clr_ovf_set", {31'd0, o_tape_ovf}, 32'd1);
    n = 0;
    while (exp_q.size() > 1 && n < 100) begin
      step();
      n++;
    end
    reset = 1'b1;
    step();
    step();
    check("abort_ovf", {31'd0, o_tape_ovf}, 32'd0);
    check("abort_ready", {31'd0, o_tape_ready}, 32'd1);
    check("abort_busy", {31'd0, o_busy}, 32'd1);
    check("abort_q", exp_q.size(), 0);
    exp_q.delete();

    // Full sweep; tape bytes queued during it drain afterwards.
    reset = 1'b0;
    for (int i = 0; i < 65536; i++) push_exp(1'b1, 16'(i), ClrVal);
    for (int i = 0; i < 4; i++) push_exp(1'b1, 16'h0900 + 16'(i), 8'hB0 + 8'(i));
    n = 0;
    while (o_busy && n < 70000) begin
      if (n < 6) begin
        i_tape_wr = 1'b1;
        i_tape_a  = 16'h0900 + 16'(n);
        i_tape_d  = 8'hB0 + 8'(n);
      end else begin
        i_tape_wr = 1'b0;
      end
      step();
      n++;
    end
    i_tape_wr = 1'b0;
    check("sweep_len", n, 65536);
    check("sweep_last_a", {16'd0, o_ram_a}, 32'h0000FFFF);
    check("sweep_ovf", {31'd0, o_tape_ovf}, 32'd1);
    wait_drain("sweep_drain");
    cpu_read(16'h1234, ClrVal);
    wait_drain("clr_read_drain");
`else
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_cpu_wait", {31'd0, o_cpu_wait}, 32'd0);
    reset = 1'b0;
    repeat (2) step();
`endif

    // CPU write then read back.
    cpu_write(16'h1234, 8'hC3);
    cpu_read(16'h1234, 8'hC3);
    wait_drain("t1_drain");

    // Idle CPU: three loader bytes then end-of-image.
    t2_a[0] = 16'h0500; t2_d[0] = 8'hA9;
    t2_a[1] = 16'h0501; t2_d[1] = 8'h00;
    t2_a[2] = 16'h0502; t2_d[2] = 8'h60;
    ce_exp = 6'b011100;
    ld_exp = 6'b100000;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        i_tape_wr = 1'b1;
        i_tape_a  = t2_a[c];
        i_tape_d  = t2_d[c];
        push_exp(1'b1, t2_a[c], t2_d[c]);
      end else begin
        i_tape_wr = 1'b0;
      end
      i_tape_done = (c == 3);
      #2;
      check($sformatf("t2_ce_c%0d", c), {31'd0, o_ram_ce}, {31'd0, ce_exp[c]});
      check($sformatf("t2_ld_c%0d", c), {31'd0, o_load_done}, {31'd0, ld_exp[c]});
      step();
    end
    i_tape_done = 1'b0;
    wait_drain("t2_drain");

    // CPU held continuously with one tape entry queued.
    i_tape_wr = 1'b1;
    i_tape_a  = 16'h0600;
    i_tape_d  = 8'h5A;
    for (int i = 0; i < 8; i++) push_exp(1'b0, 16'h1234, 8'h00);
    push_exp(1'b1, 16'h0600, 8'h5A);
    for (int i = 0; i < 3; i++) push_exp(1'b0, 16'h1234, 8'h00);
    for (int i = 0; i < 11; i++) rd_q.push_back(8'hC3);
    #2;
    check("ld_hold", {31'd0, o_load_done}, 32'd1);
    step();
    i_tape_wr = 1'b0;
    check("ld_clear", {31'd0, o_load_done}, 32'd0);
    for (int c = 1; c <= 12; c++) begin
      i_cpu_cs = 1'b1;
      i_cpu_we = 1'b0;
      i_cpu_a  = 16'h1234;
      #2;
      check($sformatf("t3_wait_c%0d", c), {31'd0, o_cpu_wait}, {31'd0, (c == 9)});
      step();
    end
    i_cpu_cs = 1'b0;
    wait_drain("t3_drain");

    // FIFO overflow while the CPU holds the port.
    for (int i = 0; i < 6; i++) push_exp(1'b0, 16'h1234, 8'h00);
    for (int i = 0; i < 4; i++) push_exp(1'b1, 16'h0700 + 16'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 6; i++) rd_q.push_back(8'hC3);
    for (int c = 0; c < 6; c++) begin
      i_cpu_cs  = 1'b1;
      i_cpu_we  = 1'b0;
      i_cpu_a   = 16'h1234;
      i_tape_wr = 1'b1;
      i_tape_a  = 16'h0700 + 16'(c);
      i_tape_d  = 8'h10 + 8'(c);
      #2;
      if (c == 3) check("t4_ready_c3", {31'd0, o_tape_ready}, 32'd1);
      if (c == 4) check("t4_ready_c4", {31'd0, o_tape_ready}, 32'd0);
      step();
    end
    i_cpu_cs  = 1'b0;
    i_tape_wr = 1'b0;
    check("t4_ovf", {31'd0, o_tape_ovf}, 32'd1);
    wait_drain("t4_drain");

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
